dds_sweep_ctrl: RTL and testbench
=================================

DDS_SWEEP_CTRL -- requirements
Module: dds_sweep_ctrl

Interface
REQ-001 Parameter W, default 6, width of all frequency tuning words (FTW).
REQ-002 Parameter DW, default 8, width of the dwell counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  synchronous active-low reset.
REQ-005 start  input  1  request a sweep; sampled only in IDLE.
REQ-006 abort  input  1  terminate an active sweep.
REQ-007 ftw_start  input  W  first FTW of the sweep.
REQ-008 ftw_stop  input  W  last FTW of the sweep.
REQ-009 ftw_step  input  W  FTW increment magnitude.
REQ-010 dwell  input  DW  extra cycles held per FTW value.
REQ-011 mode  input  2  00 single, 01 repeat, 10 ping-pong, 11 treated as 00.
REQ-012 wavesel_cfg  input  2  waveform select forwarded to the NCO.
REQ-013 amp_cfg  input  6  amplitude forwarded to the multiplier.
REQ-014 ftw_out  output  W  current FTW driven to the NCO.
REQ-015 wavesel_out  output  2  registered waveform select.
REQ-016 amp_out  output  6  registered amplitude.
REQ-017 dds_enable  output  1  NCO enable; 0 clears the phase accumulator.
REQ-018 busy  output  1  high while a sweep runs.
REQ-019 done  output  1  one-cycle pulse on normal completion.
REQ-020 wrap  output  1  one-cycle pulse at each sweep endpoint in repeat or ping-pong mode.

Function
REQ-021 States: IDLE, RUN, DONE; all outputs registered.
REQ-022 IDLE: ftw_out=0, wavesel_out=0, amp_out=0, dds_enable=0, busy=0, done=0, wrap=0.
REQ-023 IDLE with start=1 and abort=0: latch all config inputs; next cycle enter RUN.
- On entering RUN: ftw_out=ftw_start, wavesel_out=wavesel_cfg, amp_out=amp_cfg, dds_enable=1, busy=1.
- Latency from start to dds_enable=1 is 1 cycle.
REQ-024 Config inputs changing during RUN have no effect until the next start.
REQ-025 A latched ftw_step of 0 is treated as 1.
REQ-026 Direction is latched at start: up if ftw_start<=ftw_stop, else down.
REQ-027 Each FTW value is held for dwell+1 cycles; dwell=0 means one cycle per value.
REQ-028 Up step: next = min(ftw_out+ftw_step, ftw_stop), computed at W+1 bits so no wrap-around occurs.
REQ-029 Down step: next = max(ftw_out-ftw_step, ftw_stop), computed at W+1 bits so no underflow occurs.
REQ-030 Endpoint reached means the dwell has expired while ftw_out equals the current target.
REQ-031 Endpoint in mode 00/11: enter DONE.
- DONE lasts one cycle: done=1, busy=0, dds_enable=0, ftw_out=0.
- Then return to IDLE.
REQ-032 Endpoint in mode 01: ftw_out reloads ftw_start on the next cycle; wrap=1 for that cycle; stay in RUN.
REQ-033 Endpoint in mode 10: reverse direction and swap the target between ftw_start and ftw_stop; take the first step away from the endpoint; wrap=1 for that cycle.
REQ-034 ftw_start==ftw_stop: hold that value for dwell+1 cycles, then apply the endpoint rule. In mode 10, do not step, and pulse wrap every dwell+1 cycles.
REQ-035 abort=1 in RUN or DONE: enter IDLE next cycle with IDLE outputs and no done pulse. abort has priority over an endpoint in the same cycle.
REQ-036 start while busy is ignored; start and abort together in IDLE are ignored.

Reset
REQ-037 rst_n=0 at a clock edge forces IDLE and IDLE output values, including mid-sweep, with no done or wrap pulse.
REQ-038 No output depends on a power-up initial value.

Verification
REQ-039 Single up sweep: start=2, stop=10, step=3, dwell=1, mode 00. Required ftw_out sequence: 2,2,5,5,8,8,10,10. Then one DONE cycle with done=1 and ftw_out=0, then IDLE.
REQ-040 Down sweep with clamp: start=60, stop=5, step=20, dwell=0, mode 00. Required sequence: 60,40,20,5, then done pulse.
REQ-041 Ping-pong: start=0, stop=63, step=32, dwell=0, mode 10. Required sequence: 0,32,63,31,0,32,...
- wrap=1 on the cycles showing 31 and 32 (the first step after each endpoint).
- No overflow past 63.
REQ-042 Repeat with step=0: start=4, stop=6, dwell=0, mode 01. Required sequence: 4,5,6,4,5,6, with wrap=1 on each reload to 4.
REQ-043 Abort and reset mid-sweep:
- abort after 3 RUN cycles: IDLE outputs next cycle, done stays 0.
- start pulsed during RUN changes nothing.
- rst_n=0 mid-sweep: IDLE outputs at the next edge.

Source files
------------

// File: rtl/dds_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// dds_sweep_ctrl
//   Frequency-sweep sequencer for a small DDS. On start it latches a sweep
//   description (start/stop tuning word, step, dwell, mode, waveform and
//   amplitude) and walks ftw_out from ftw_start towards ftw_stop. Each value is
//   held for dwell+1 cycles. At the sweep endpoint it finishes (single),
//   reloads the start value (repeat) or reverses direction (ping-pong).
//
// Ports
//   clk, rst_n        clock, synchronous active-low reset
//   start, abort      sweep request (IDLE only) / sweep termination
//   ftw_start/stop    sweep endpoints (W bits)
//   ftw_step          step magnitude, 0 behaves as 1
//   dwell             extra hold cycles per value (DW bits)
//   mode              00 single, 01 repeat, 10 ping-pong, 11 single
//   wavesel_cfg/amp   forwarded to wavesel_out / amp_out while running
//   ftw_out           tuning word to the NCO
//   dds_enable        NCO enable (0 clears the phase accumulator)
//   busy, done, wrap  status: running / completion pulse / endpoint pulse
//   state_dbg         current FSM state (IDLE=0, RUN=1, DONE=2)
//
// Handshake: start is a level sampled on a rising edge while IDLE and abort is
// low; there is no acknowledge other than busy rising on the next cycle.
// abort is sampled every edge in RUN/DONE and always wins over an endpoint.
// -----------------------------------------------------------------------------
module dds_sweep_ctrl #(
  parameter int W  = 6,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic [W-1:0]  ftw_start,
  input  logic [W-1:0]  ftw_stop,
  input  logic [W-1:0]  ftw_step,
  input  logic [DW-1:0] dwell,
  input  logic [1:0]    mode,
  input  logic [1:0]    wavesel_cfg,
  input  logic [5:0]    amp_cfg,
  output logic [W-1:0]  ftw_out,
  output logic [1:0]    wavesel_out,
  output logic [5:0]    amp_out,
  output logic          dds_enable,
  output logic          busy,
  output logic          done,
  output logic          wrap,
  output logic [1:0]    state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [1:0] MODE_REPEAT = 2'b01;
  localparam logic [1:0] MODE_PINGPONG = 2'b10;

  state_t        state_q, state_d;
  logic [W-1:0]  ftw_q, ftw_d;
  logic [1:0]    wavesel_q, wavesel_d;
  logic [5:0]    amp_q, amp_d;
  logic          en_q, en_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          wrap_q, wrap_d;

  // Latched sweep description.
  logic [W-1:0]  a_q, a_d;         // ftw_start
  logic [W-1:0]  b_q, b_d;         // ftw_stop
  logic [W-1:0]  step_q, step_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [1:0]    mode_q, mode_d;
  logic          up_q, up_d;       // current walking direction
  logic          tgt_b_q, tgt_b_d; // 1: heading for ftw_stop, 0: for ftw_start
  logic [DW-1:0] cnt_q, cnt_d;     // cycles already spent on the current value

  logic [W-1:0]  target;
  logic [W-1:0]  rev_target;

  // One step towards tgt, clamped at tgt. The W+1 bit arithmetic keeps the
  // carry/borrow visible so a big step can never wrap past the endpoint.
  function automatic logic [W-1:0] step_fn(input logic [W-1:0] cur,
                                           input logic          up,
                                           input logic [W-1:0]  tgt,
                                           input logic [W-1:0]  stp);
    logic [W:0] ext;
    logic [W-1:0] res;
    if (up) begin
      ext = {1'b0, cur} + {1'b0, stp};
      res = (ext > {1'b0, tgt}) ? tgt : ext[W-1:0];
    end else begin
      ext = {1'b0, cur} - {1'b0, stp};
      res = (ext[W] || (ext[W-1:0] < tgt)) ? tgt : ext[W-1:0];
    end
    return res;
  endfunction

  assign target     = tgt_b_q ? b_q : a_q;
  assign rev_target = tgt_b_q ? a_q : b_q;

  always_comb begin
    state_d   = state_q;
    ftw_d     = ftw_q;
    wavesel_d = wavesel_q;
    amp_d     = amp_q;
    en_d      = en_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    wrap_d    = 1'b0;
    a_d       = a_q;
    b_d       = b_q;
    step_d    = step_q;
    dwell_d   = dwell_q;
    mode_d    = mode_q;
    up_d      = up_q;
    tgt_b_d   = tgt_b_q;
    cnt_d     = cnt_q;

    case (state_q)
      S_IDLE: begin
        ftw_d     = '0;
        wavesel_d = '0;
        amp_d     = '0;
        en_d      = 1'b0;
        busy_d    = 1'b0;
        if (start && !abort) begin
          state_d   = S_RUN;
          a_d       = ftw_start;
          b_d       = ftw_stop;
          step_d    = (ftw_step == '0) ? {{(W-1){1'b0}}, 1'b1} : ftw_step;
          dwell_d   = dwell;
          mode_d    = mode;
          up_d      = (ftw_start <= ftw_stop);
          tgt_b_d   = 1'b1;
          cnt_d     = '0;
          ftw_d     = ftw_start;
          wavesel_d = wavesel_cfg;
          amp_d     = amp_cfg;
          en_d      = 1'b1;
          busy_d    = 1'b1;
        end
      end

      S_RUN: begin
        if (abort) begin
          state_d   = S_IDLE;
          ftw_d     = '0;
          wavesel_d = '0;
          amp_d     = '0;
          en_d      = 1'b0;
          busy_d    = 1'b0;
        end else if (cnt_q == dwell_q) begin
          cnt_d = '0;
          if (ftw_q == target) begin
            if (mode_q == MODE_REPEAT) begin
              ftw_d  = a_q;
              wrap_d = 1'b1;
            end else if (mode_q == MODE_PINGPONG) begin
              // Turn around and take the first step immediately; with equal
              // endpoints the clamp keeps the value where it is.
              up_d    = !up_q;
              tgt_b_d = !tgt_b_q;
              ftw_d   = step_fn(ftw_q, !up_q, rev_target, step_q);
              wrap_d  = 1'b1;
            end else begin
              state_d   = S_DONE;
              ftw_d     = '0;
              wavesel_d = '0;
              amp_d     = '0;
              en_d      = 1'b0;
              busy_d    = 1'b0;
              done_d    = 1'b1;
            end
          end else begin
            ftw_d = step_fn(ftw_q, up_q, target, step_q);
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_DONE: begin
        // Outputs already at idle values; done drops via its default.
        state_d = S_IDLE;
      end

      default: begin
        state_d   = S_IDLE;
        ftw_d     = '0;
        wavesel_d = '0;
        amp_d     = '0;
        en_d      = 1'b0;
        busy_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      ftw_q     <= '0;
      wavesel_q <= '0;
      amp_q     <= '0;
      en_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      wrap_q    <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      step_q    <= '0;
      dwell_q   <= '0;
      mode_q    <= '0;
      up_q      <= 1'b0;
      tgt_b_q   <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      ftw_q     <= ftw_d;
      wavesel_q <= wavesel_d;
      amp_q     <= amp_d;
      en_q      <= en_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      wrap_q    <= wrap_d;
      a_q       <= a_d;
      b_q       <= b_d;
      step_q    <= step_d;
      dwell_q   <= dwell_d;
      mode_q    <= mode_d;
      up_q      <= up_d;
      tgt_b_q   <= tgt_b_d;
      cnt_q     <= cnt_d;
    end
  end

  assign ftw_out     = ftw_q;
  assign wavesel_out = wavesel_q;
  assign amp_out     = amp_q;
  assign dds_enable  = en_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign wrap        = wrap_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
module tb_dds_sweep_ctrl;
  localparam int W  = 6;
  localparam int DW = 8;
  localparam int RW = 2 + 6 + W + 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [W-1:0]  ftw_start = '0, ftw_stop = '0, ftw_step = '0;
  logic [DW-1:0] dwell = '0;
  logic [1:0]    mode = '0, wavesel_cfg = '0;
  logic [5:0]    amp_cfg = '0;
  logic [W-1:0]  ftw_out;
  logic [1:0]    wavesel_out, state_dbg;
  logic [5:0]    amp_out;
  logic          dds_enable, busy, done, wrap;

  dds_sweep_ctrl #(.W(W), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .ftw_start(ftw_start), .ftw_stop(ftw_stop), .ftw_step(ftw_step),
    .dwell(dwell), .mode(mode), .wavesel_cfg(wavesel_cfg), .amp_cfg(amp_cfg),
    .ftw_out(ftw_out), .wavesel_out(wavesel_out), .amp_out(amp_out),
    .dds_enable(dds_enable), .busy(busy), .done(done), .wrap(wrap),
    .state_dbg(state_dbg)
  );

  // ---------------- scoreboard ----------------
  // record = {wavesel, amp, ftw, dds_enable, busy, done, wrap}
  logic [RW-1:0] exp_q[$];
  logic [RW-1:0] exp_r, act_r;
  int n_checks = 0;
  int n_fail   = 0;

  function automatic void push_exp(input logic [W-1:0] f, input logic en,
                                   input logic bz, input logic dn, input logic wr,
                                   input logic [1:0] ws, input logic [5:0] am);
    exp_q.push_back({ws, am, f, en, bz, dn, wr});
  endfunction

  function automatic void push_idle();
    exp_q.push_back('0);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic scramble_cfg();
    ftw_start   = W'($urandom_range(0, 63));
    ftw_stop    = W'($urandom_range(0, 63));
    ftw_step    = W'($urandom_range(0, 63));
    dwell       = DW'($urandom_range(0, 255));
    mode        = 2'($urandom_range(0, 3));
    wavesel_cfg = 2'($urandom_range(0, 3));
    amp_cfg     = 6'($urandom_range(0, 63));
  endtask

  // Called on a negedge; returns on the negedge showing the first RUN value.
  task automatic kick(input logic [W-1:0] fs, input logic [W-1:0] fe,
                      input logic [W-1:0] st, input logic [DW-1:0] dw,
                      input logic [1:0] md, input logic [1:0] ws,
                      input logic [5:0] am);
    ftw_start = fs; ftw_stop = fe; ftw_step = st; dwell = dw;
    mode = md; wavesel_cfg = ws; amp_cfg = am;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    scramble_cfg();
  endtask

  task automatic do_abort();
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    scramble_cfg();
    start = 1'b1;
    repeat (2) @(negedge clk);
    start = 1'b0;
    push_idle();
    push_idle();
    while (exp_q.size() > 0) begin
      exp_r = exp_q.pop_front();
      act_r = {wavesel_out, amp_out, ftw_out, dds_enable, busy, done, wrap};
      n_checks++;
      if (act_r !== exp_r) begin
        n_fail++;
        $display("FAIL reset: got %h expected %h", act_r, exp_r);
      end
      if (exp_q.size() == 1) rst_n = 1'b1;
      @(negedge clk);
    end
    n_checks++;
    if (state_dbg !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_state: got %0d expected 0", state_dbg);
    end
  endtask

  task automatic test_up_sweep();
    int vals[8] = '{2, 2, 5, 5, 8, 8, 10, 10};
    foreach (vals[i]) push_exp(W'(vals[i]), 1, 1, 0, 0, 2'd2, 6'h2a);
    push_exp(0, 0, 0, 1, 0, 0, 0);
    push_idle();
    push_idle();
    kick(2, 10, 3, 1, 2'b00, 2'd2, 6'h2a);
    while (exp_q.size() > 0) begin
      exp_r = exp_q.pop_front();
      act_r = {wavesel_out, amp_out, ftw_out, dds_enable, busy, done, wrap};
      n_checks++;
      if (act_r !== exp_r) begin
        n_fail++;
        $display("FAIL up_sweep: got %h expected %h", act_r, exp_r);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_down_sweep();
    int vals[4] = '{60, 40, 20, 5};
    foreach (vals[i]) push_exp(W'(vals[i]), 1, 1, 0, 0, 2'd1, 6'h15);
    push_exp(0, 0, 0, 1, 0, 0, 0);
    push_idle();
    kick(60, 5, 20, 0, 2'b00, 2'd1, 6'h15);
    while (exp_q.size() > 0) begin
      exp_r = exp_q.pop_front();
      act_r = {wavesel_out, amp_out, ftw_out, dds_enable, busy, done, wrap};
      n_checks++;
      if (act_r !== exp_r) begin
        n_fail++;
        $display("FAIL down_sweep: got %h expected %h", act_r, exp_r);
      end
      @(negedge clk);
    end
  endtask

  // mode 11 acts as single; equal endpoints hold for dwell+1 cycles.
  task automatic test_equal_single();
    repeat (3) push_exp(7, 1, 1, 0, 0, 2'd3, 6'h3f);
    push_exp(0, 0, 0, 1, 0, 0, 0);
    push_idle();
    kick(7, 7, 4, 2, 2'b11, 2'd3, 6'h3f);
    while (exp_q.size() > 0) begin
      exp_r = exp_q.pop_front();
      act_r = {wavesel_out, amp_out, ftw_out, dds_enable, busy, done, wrap};
      n_checks++;
      if (act_r !== exp_r) begin
        n_fail++;
        $display("FAIL equal_single: got %h expected %h", act_r, exp_r);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_pingpong();
    int vals[9] = '{0, 32, 63, 31, 0, 32, 63, 31, 0};
    int wr[9]   = '{0, 0, 0, 1, 0, 1, 0, 1, 0};
    foreach (vals[i]) push_exp(W'(vals[i]), 1, 1, 0, wr[i][0], 2'd0, 6'h01);
    push_idle();
    push_idle();
    kick(0, 63, 32, 0, 2'b10, 2'd0, 6'h01);
    while (exp_q.size() > 0) begin
      exp_r = exp_q.pop_front();
      act_r = {wavesel_out, amp_out, ftw_out, dds_enable, busy, done, wrap};
      n_checks++;
      if (act_r !== exp_r) begin
        n_fail++;
        $display("FAIL pingpong: got %h expected %h", act_r, exp_r);
      end
      abort = (exp_q.size() == 2);
      @(negedge clk);
    end
    abort = 1'b0;
  endtask

  task automatic test_pingpong_equal();
    int wr[6] = '{0, 0, 1, 0, 1, 0};
    foreach (wr[i]) push_exp(9, 1, 1, 0, wr[i][0], 2'd2, 6'h07);
    push_idle();
    kick(9, 9, 5, 1, 2'b10, 2'd2, 6'h07);
    while (exp_q.size() > 0) begin
      exp_r = exp_q.pop_front();
      act_r = {wavesel_out, amp_out, ftw_out, dds_enable, busy, done, wrap};
      n_checks++;
      if (act_r !== exp_r) begin
        n_fail++;
        $display("FAIL pingpong_equal: got %h expected %h", act_r, exp_r);
      end
      abort = (exp_q.size() == 1);
      @(negedge clk);
    end
    abort = 1'b0;
  endtask

  task automatic test_repeat();
    int vals[8] = '{4, 5, 6, 4, 5, 6, 4, 5};
    int wr[8]   = '{0, 0, 0, 1, 0, 0, 1, 0};
    foreach (vals[i]) push_exp(W'(vals[i]), 1, 1, 0, wr[i][0], 2'd1, 6'h22);
    push_idle();
    kick(4, 6, 0, 0, 2'b01, 2'd1, 6'h22);
    while (exp_q.size() > 0) begin
      exp_r = exp_q.pop_front();
      act_r = {wavesel_out, amp_out, ftw_out, dds_enable, busy, done, wrap};
      n_checks++;
      if (act_r !== exp_r) begin
        n_fail++;
        $display("FAIL repeat: got %h expected %h", act_r, exp_r);
      end
      abort = (exp_q.size() == 1);
      @(negedge clk);
    end
    abort = 1'b0;
  endtask

  // abort after 3 RUN cycles, with a start pulse and new config mid-run.
  task automatic test_abort_mid();
    int vals[3] = '{2, 2, 5};
    int k = 0;
    foreach (vals[i]) push_exp(W'(vals[i]), 1, 1, 0, 0, 2'd2, 6'h11);
    push_idle();
    push_idle();
    push_idle();
    kick(2, 10, 3, 1, 2'b00, 2'd2, 6'h11);
    while (exp_q.size() > 0) begin
      exp_r = exp_q.pop_front();
      act_r = {wavesel_out, amp_out, ftw_out, dds_enable, busy, done, wrap};
      n_checks++;
      if (act_r !== exp_r) begin
        n_fail++;
        $display("FAIL abort_mid cyc%0d: got %h expected %h", k, act_r, exp_r);
      end
      start = (k == 0);
      if (k == 0) begin
        ftw_start = 40; ftw_stop = 41; mode = 2'b01;
      end
      abort = (k == 2);
      k++;
      @(negedge clk);
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic test_reset_mid();
    push_exp(20, 1, 1, 0, 0, 2'd3, 6'h05);
    push_exp(20, 1, 1, 0, 0, 2'd3, 6'h05);
    push_idle();
    push_idle();
    kick(20, 30, 1, 3, 2'b00, 2'd3, 6'h05);
    while (exp_q.size() > 0) begin
      exp_r = exp_q.pop_front();
      act_r = {wavesel_out, amp_out, ftw_out, dds_enable, busy, done, wrap};
      n_checks++;
      if (act_r !== exp_r) begin
        n_fail++;
        $display("FAIL reset_mid: got %h expected %h", act_r, exp_r);
      end
      rst_n = (exp_q.size() != 2);
      @(negedge clk);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_start_abort_idle();
    push_idle();
    push_idle();
    ftw_start = 3; ftw_stop = 9; ftw_step = 1; mode = 2'b00;
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    while (exp_q.size() > 0) begin
      exp_r = exp_q.pop_front();
      act_r = {wavesel_out, amp_out, ftw_out, dds_enable, busy, done, wrap};
      n_checks++;
      if (act_r !== exp_r) begin
        n_fail++;
        $display("FAIL start_abort_idle: got %h expected %h", act_r, exp_r);
      end
      @(negedge clk);
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "timeout");
  end

  // ---------------- sequence + report ----------------
  initial begin
    @(negedge clk);
    test_reset();
    test_up_sweep();
    test_down_sweep();
    test_equal_single();
    test_pingpong();
    test_pingpong_equal();
    test_repeat();
    test_abort_mid();
    test_reset_mid();
    test_start_abort_idle();
    test_up_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
